converter_frame_ctrl: RTL
=========================

# converter_frame_ctrl

Frame scheduler for the TDM↔STM converter datapath. Runs on the c4 bit clock and locks to the active-low f0 frame pulse. Generates the per-frame tx load/shift and rx shift/latch strobes that sequence the converter shift registers. Also owns the cpu_int handshake to the STM and reports sync and buffer errors.

## Interface
Parameters:
- FRAME_LEN, 32: c4 cycles per frame (bits per frame)
- TX_OFS, 1: bit_cnt of first tx shift
- TX_BITS, 30: tx shift cycles per frame
- RX_OFS, 2: bit_cnt of first rx shift
- RX_BITS, 29: rx shift cycles per frame; RX_OFS+RX_BITS ≤ FRAME_LEN-1
- MISS_MAX, 2: consecutive missing f0 pulses before sync loss

Ports:
- c4  in  1  bit clock; the only clock
- reset_rg  in  1  synchronous, active-high reset
- f0  in  1  frame sync, active low, synchronous to c4
- tx_valid  in  1  STM tx buffer holds a fresh frame
- int_ack  in  1  one-cycle STM acknowledge of cpu_int
- tx_load  out  1  load tx shift register from STM buffer
- tx_shift_en  out  1  shift tx register one bit
- rx_shift_en  out  1  shift rx register one bit
- rx_latch  out  1  copy rx shift register to STM-readable buffer
- cpu_int  out  1  rx frame ready, level until acked
- locked  out  1  frame sync held
- bit_cnt  out  $clog2(FRAME_LEN)  position in frame, 0 = frame start
- frame_err  out  1  pulse: early f0 or sync loss
- tx_underrun  out  1  pulse: tx_load with tx_valid low
- rx_overrun  out  1  pulse: rx_latch while cpu_int high

## Operation
- Edge detect: fall = f0_q & ~f0. f0_q resets to 1.
- States: HUNT, LOCKED.
- HUNT: bit_cnt holds 0 and all strobes are low. On fall, go to LOCKED with bit_cnt=0 in the same cycle, and this cycle is frame start S.
- LOCKED: bit_cnt increments and wraps FRAME_LEN-1→0.
  - fall when bit_cnt==0: on time, miss_cnt=0.
  - bit_cnt wraps to 0 without fall: miss_cnt+1, freewheel. When miss_cnt reaches MISS_MAX: go to HUNT, frame_err pulse.
  - fall when bit_cnt≠0: early. frame_err pulse, bit_cnt forced to 0 (new S), current frame aborted, no rx_latch for it.
- Strobes, LOCKED only, decoded from bit_cnt:
  - tx_load at bit_cnt==0.
  - tx_shift_en for TX_OFS ≤ bit_cnt < TX_OFS+TX_BITS.
  - rx_shift_en for RX_OFS ≤ bit_cnt < RX_OFS+RX_BITS.
  - rx_latch at bit_cnt==RX_OFS+RX_BITS, only if that frame's full rx window completed since the last S.
- tx_underrun = tx_load & ~tx_valid. The load still occurs.
- cpu_int: set by rx_latch, cleared by int_ack.
  - rx_latch and int_ack in the same cycle: cpu_int stays 1, no overrun.
  - rx_latch while cpu_int=1 and no ack: rx_overrun pulse, cpu_int stays 1.
  - int_ack while cpu_int=0: ignored.
- Reset, all outputs: state HUNT, bit_cnt=0, miss_cnt=0, cpu_int=0, all strobes and pulses 0, locked=0.

## Timing
- Strobes are combinational from registered state/bit_cnt: zero latency relative to bit_cnt.
- The fall cycle itself shows bit_cnt=0, so tx_load asserts in the cycle f0 is first sampled low.
- Default frame: tx_load @0, tx_shift_en @1..30, rx_shift_en @2..30, rx_latch @31.
- cpu_int rises the cycle after rx_latch and falls the cycle after int_ack.
- locked = (state==LOCKED), registered.
- Reset mid-frame: the next cycle is HUNT with all outputs at reset values. A frame resumes only on a new fall.
- f0 held low: only one fall, no repeated start.

## Structure
- converter_pkg: state enum (HUNT, LOCKED) and default frame constants shared with the converter datapath.
- Sub-module converter_sync_tracker: f0 edge detect, HUNT/LOCKED FSM, bit_cnt, miss_cnt, frame_err.
- Top level adds strobe decode, the rx-window-complete flag and the cpu_int handshake.

## Test plan
- Reset, then f0 low one cycle every 32 cycles → locked=1 at first pulse; tx_load@0, tx_shift_en 30 cycles, rx_latch@31 each frame; frame_err never asserts.
- Drop two consecutive f0 pulses (MISS_MAX=2) → freewheel one frame with strobes, frame_err at second missed wrap, locked=0, strobes stop.
- f0 pulse at bit_cnt=10 → frame_err pulse, bit_cnt=0 same cycle, no rx_latch for aborted frame, normal latch at 31 of the new frame.
- No int_ack for two frames → cpu_int=1 after first latch, rx_overrun pulse at second latch; int_ack coincident with a latch → cpu_int stays 1, no overrun.
- tx_valid=0 at frame start → tx_underrun pulse with tx_load. Assert reset_rg at bit_cnt=15 → all outputs 0 next cycle and HUNT until the next f0 fall.

Source files
------------

// File: rtl/converter_pkg.sv
// Shared definitions for the TDM<->STM converter: sync state encoding,
// default frame geometry and a window decode helper.
package converter_pkg;

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } sync_state_t;

   localparam int DEF_FRAME_LEN = 32;
   localparam int DEF_TX_OFS    = 1;
   localparam int DEF_TX_BITS   = 30;
   localparam int DEF_RX_OFS    = 2;
   localparam int DEF_RX_BITS   = 29;
   localparam int DEF_MISS_MAX  = 2;

   // True when pos lies in the half-open range [ofs, ofs+bits).
   function automatic logic in_window(input logic [31:0] pos, input int ofs, input int bits);
      return (pos >= 32'(ofs)) && (pos < 32'(ofs + bits));
   endfunction

endpackage

// File: rtl/converter_sync_tracker.sv
// Frame sync tracker: detects f0 falling edges, hunts/locks to the frame,
// keeps the in-frame bit position and flags early pulses and sync loss.
module converter_sync_tracker
   import converter_pkg::*;
#(
   parameter int FRAME_LEN = DEF_FRAME_LEN,
   parameter int MISS_MAX  = DEF_MISS_MAX
) (
   input  logic                         c4,
   input  logic                         reset_rg,
   input  logic                         f0,
   output logic                         active,
   output logic [$clog2(FRAME_LEN)-1:0] bit_cnt,
   output logic                         locked,
   output logic                         frame_err
);

   localparam int CW = $clog2(FRAME_LEN);
   localparam int MW = $clog2(MISS_MAX + 1);
   localparam logic [CW-1:0] LAST     = CW'(FRAME_LEN - 1);
   localparam logic [MW-1:0] MISS_TOP = MW'(MISS_MAX - 1);

   sync_state_t   state, state_nxt;
   logic [CW-1:0] cnt_q, cnt_nxt;
   logic [MW-1:0] miss_q, miss_nxt;
   logic          f0_q;
   logic          fall;

   assign fall   = f0_q & ~f0;
   assign locked = (state == LOCKED);

   always_ff @(posedge c4) begin
      if (reset_rg) begin
         state  <= HUNT;
         cnt_q  <= '0;
         miss_q <= '0;
         f0_q   <= 1'b1;
      end else begin
         state  <= state_nxt;
         cnt_q  <= cnt_nxt;
         miss_q <= miss_nxt;
         f0_q   <= f0;
      end
   end

   // A fall shows as position 0 in the very cycle it is seen, so the
   // registered count always holds the position of the following cycle's
   // frame unless a new fall overrides it.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt_q;
      miss_nxt  = miss_q;
      bit_cnt   = cnt_q;
      active    = 1'b0;
      frame_err = 1'b0;
      case (state)
         HUNT: begin
            cnt_nxt  = '0;
            miss_nxt = '0;
            if (fall) begin
               state_nxt = LOCKED;
               active    = 1'b1;
               bit_cnt   = '0;
               cnt_nxt   = CW'(1);
            end
         end
         LOCKED: begin
            active  = 1'b1;
            cnt_nxt = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
            if (fall) begin
               bit_cnt   = '0;
               cnt_nxt   = CW'(1);
               miss_nxt  = '0;
               frame_err = (cnt_q != '0);
            end else if (cnt_q == '0) begin
               // Expected frame start passed with no pulse.
               if (miss_q == MISS_TOP) begin
                  state_nxt = HUNT;
                  active    = 1'b0;
                  frame_err = 1'b1;
                  cnt_nxt   = '0;
                  miss_nxt  = '0;
               end else begin
                  miss_nxt = miss_q + MW'(1);
               end
            end
         end
         default: begin
            state_nxt = HUNT;
            cnt_nxt   = '0;
            miss_nxt  = '0;
         end
      endcase
   end

endmodule

// File: rtl/converter_frame_ctrl.sv
// Frame scheduler top: decodes tx/rx strobes from the sync tracker's bit
// position and runs the cpu_int handshake toward the STM.
module converter_frame_ctrl
   import converter_pkg::*;
#(
   parameter int FRAME_LEN = DEF_FRAME_LEN,
   parameter int TX_OFS    = DEF_TX_OFS,
   parameter int TX_BITS   = DEF_TX_BITS,
   parameter int RX_OFS    = DEF_RX_OFS,
   parameter int RX_BITS   = DEF_RX_BITS,
   parameter int MISS_MAX  = DEF_MISS_MAX
) (
   input  logic                         c4,
   input  logic                         reset_rg,
   input  logic                         f0,
   input  logic                         tx_valid,
   input  logic                         int_ack,
   output logic                         tx_load,
   output logic                         tx_shift_en,
   output logic                         rx_shift_en,
   output logic                         rx_latch,
   output logic                         cpu_int,
   output logic                         locked,
   output logic [$clog2(FRAME_LEN)-1:0] bit_cnt,
   output logic                         frame_err,
   output logic                         tx_underrun,
   output logic                         rx_overrun
);

   localparam logic [31:0] RX_END  = 32'(RX_OFS + RX_BITS);
   localparam logic [31:0] RX_LAST = 32'(RX_OFS + RX_BITS - 1);

   logic        active;
   logic [31:0] pos;
   logic        rx_done;

   converter_sync_tracker #(
      .FRAME_LEN (FRAME_LEN),
      .MISS_MAX  (MISS_MAX)
   ) u_sync (
      .c4        (c4),
      .reset_rg  (reset_rg),
      .f0        (f0),
      .active    (active),
      .bit_cnt   (bit_cnt),
      .locked    (locked),
      .frame_err (frame_err)
   );

   assign pos = 32'(bit_cnt);

   always_comb begin
      tx_load     = active && (pos == 32'd0);
      tx_shift_en = active && in_window(pos, TX_OFS, TX_BITS);
      rx_shift_en = active && in_window(pos, RX_OFS, RX_BITS);
      rx_latch    = active && (pos == RX_END) && rx_done;
      tx_underrun = tx_load && !tx_valid;
      rx_overrun  = rx_latch && cpu_int && !int_ack;
   end

   // rx_done marks that the last rx bit of the current frame was shifted;
   // any new frame start (including an early one) discards it.
   always_ff @(posedge c4) begin
      if (reset_rg) begin
         rx_done <= 1'b0;
      end else if (!active || tx_load || rx_latch) begin
         rx_done <= 1'b0;
      end else if (rx_shift_en && (pos == RX_LAST)) begin
         rx_done <= 1'b1;
      end
   end

   // A latch wins over a coincident acknowledge so the new frame is not lost.
   always_ff @(posedge c4) begin
      if (reset_rg) begin
         cpu_int <= 1'b0;
      end else if (rx_latch) begin
         cpu_int <= 1'b1;
      end else if (int_ack) begin
         cpu_int <= 1'b0;
      end
   end

endmodule
